// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register-file geometry and the hard-wired zero register.
package mips_pkg;

    localparam int unsigned BITS_REGS = 5;
    localparam int unsigned NUM_REGS  = 2 ** BITS_REGS;
    localparam int unsigned BITS_DATA = 32;

    localparam logic [BITS_REGS-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port with $0 masking.
// Optional write-through bypass when REGFILE_BYPASS_EN is defined.
module regfile_read_port
    import mips_pkg::*;
(
    input  logic [NUM_REGS-1:0][BITS_DATA-1:0] regs,
    input  logic [BITS_REGS-1:0]               addr,
    input  logic                               commit,
    input  logic [BITS_REGS-1:0]               wr_addr,
    input  logic [BITS_DATA-1:0]               wr_data,
    output logic [BITS_DATA-1:0]               data
);

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        data = regs[addr];
        // commit already excludes $0, so the bypass can never leak into $0 reads
        if (commit && (wr_addr == addr)) begin
            data = wr_data;
        end
        if (addr == REG_ZERO) begin
            data = '0;
        end
    end
`else
    logic unused_wr_side;
    assign unused_wr_side = commit ^ (^wr_addr) ^ (^wr_data);

    always_comb begin
        data = regs[addr];
        if (addr == REG_ZERO) begin
            data = '0;
        end
    end
`endif

endmodule

// File: rtl/register_file.sv
// 32-entry MIPS register file: two ID read ports, one debug read port, one WB write port,
// plus a committed-write counter. Define REGFILE_BYPASS_EN for same-cycle write-through reads.
module register_file
    import mips_pkg::*;
#(
    parameter int unsigned BITS_CNT = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_step_en,
    input  logic                 i_ctl_reg_write,
    input  logic [BITS_REGS-1:0] i_wr_addr,
    input  logic [BITS_DATA-1:0] i_wr_data,
    input  logic [BITS_REGS-1:0] i_rs,
    input  logic [BITS_REGS-1:0] i_rt,
    input  logic [BITS_REGS-1:0] i_dbg_addr,
    output logic [BITS_DATA-1:0] o_data_rs,
    output logic [BITS_DATA-1:0] o_data_rt,
    output logic [BITS_DATA-1:0] o_dbg_data,
    output logic [BITS_CNT-1:0]  o_wr_count,
    output logic [BITS_REGS-1:0] o_last_wr_addr
);

    logic [NUM_REGS-1:0][BITS_DATA-1:0] regs_q;
    logic [BITS_CNT-1:0]                wr_count_q;
    logic [BITS_REGS-1:0]               last_wr_addr_q;
    logic                               commit;

    assign commit = i_step_en & i_ctl_reg_write & (i_wr_addr != REG_ZERO);

    // Reset loads reg[i] = i so debug dumps show a recognisable pattern; reg[0] lands on 0.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= BITS_DATA'(i);
            end
            wr_count_q     <= '0;
            last_wr_addr_q <= REG_ZERO;
        end else if (commit) begin
            regs_q[i_wr_addr] <= i_wr_data;
            wr_count_q        <= wr_count_q + BITS_CNT'(1);
            last_wr_addr_q    <= i_wr_addr;
        end
    end

    assign o_wr_count     = wr_count_q;
    assign o_last_wr_addr = last_wr_addr_q;

    regfile_read_port u_port_rs (
        .regs    (regs_q),
        .addr    (i_rs),
        .commit  (commit),
        .wr_addr (i_wr_addr),
        .wr_data (i_wr_data),
        .data    (o_data_rs)
    );

    regfile_read_port u_port_rt (
        .regs    (regs_q),
        .addr    (i_rt),
        .commit  (commit),
        .wr_addr (i_wr_addr),
        .wr_data (i_wr_data),
        .data    (o_data_rt)
    );

    regfile_read_port u_port_dbg (
        .regs    (regs_q),
        .addr    (i_dbg_addr),
        .commit  (commit),
        .wr_addr (i_wr_addr),
        .wr_data (i_wr_data),
        .data    (o_dbg_data)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file (counter narrowed to 4 bits to reach the wrap).
module tb_register_file;

    localparam int unsigned CW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        step_en;
    logic        ctl_reg_write;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dbg_addr;
    logic [31:0] data_rs;
    logic [31:0] data_rt;
    logic [31:0] dbg_data;
    logic [CW-1:0] wr_count;
    logic [4:0]  last_wr_addr;

    int tests = 0;
    int fails = 0;

    register_file #(.BITS_CNT(CW)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_step_en       (step_en),
        .i_ctl_reg_write (ctl_reg_write),
        .i_wr_addr       (wr_addr),
        .i_wr_data       (wr_data),
        .i_rs            (rs),
        .i_rt            (rt),
        .i_dbg_addr      (dbg_addr),
        .o_data_rs       (data_rs),
        .o_data_rt       (data_rt),
        .o_dbg_data      (dbg_data),
        .o_wr_count      (wr_count),
        .o_last_wr_addr  (last_wr_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        step;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dbg;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
        logic [31:0] exp_dbg;
        logic [31:0] exp_cnt;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Drive write side and read addresses just after a rising edge.
    task automatic drive(input logic st, input logic we, input logic [4:0] a, input logic [31:0] d,
                         input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd);
        step_en       = st;
        ctl_reg_write = we;
        wr_addr       = a;
        wr_data       = d;
        rs            = ra;
        rt            = rb;
        dbg_addr      = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ctl_reg_write = 1'b0;
        #1;
    endtask

    logic [31:0] exp_same;

    initial begin
        vecs[0] = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  5'd5,
                    32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'd1, 32'd5};
        vecs[1] = '{1'b1, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  5'd0,
                    32'h0, 32'h0, 32'h0, 32'd1, 32'd5};
        vecs[2] = '{1'b0, 1'b1, 5'd9,  32'h12345678, 5'd9,  5'd9,  5'd5,
                    32'd9, 32'd9, 32'hDEADBEEF, 32'd1, 32'd5};
        vecs[3] = '{1'b1, 1'b1, 5'd9,  32'h12345678, 5'd9,  5'd5,  5'd31,
                    32'h12345678, 32'hDEADBEEF, 32'd31, 32'd2, 32'd9};
        vecs[4] = '{1'b1, 1'b0, 5'd10, 32'h00000001, 5'd10, 5'd10, 5'd10,
                    32'd10, 32'd10, 32'd10, 32'd2, 32'd9};
        vecs[5] = '{1'b1, 1'b1, 5'd31, 32'h0BADF00D, 5'd31, 5'd30, 5'd31,
                    32'h0BADF00D, 32'd30, 32'h0BADF00D, 32'd3, 32'd31};

        // Reset with a concurrent write to $3: reset must win.
        reset = 1'b1;
        drive(1'b1, 1'b1, 5'd3, 32'hFFFF0000, 5'd7, 5'd0, 5'd31);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ctl_reg_write = 1'b0;
        #1;
        check("reset_rs7", data_rs, 32'd7);
        check("reset_rt0", data_rt, 32'd0);
        check("reset_dbg31", dbg_data, 32'd31);
        check("reset_cnt", 32'(wr_count), 32'd0);
        check("reset_last", 32'(last_wr_addr), 32'd0);
        rs = 5'd3;
        #1;
        check("reset_beats_write", data_rs, 32'd3);

        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].step, vecs[i].we, vecs[i].addr, vecs[i].data,
                  vecs[i].rs, vecs[i].rt, vecs[i].dbg);
            tick();
            check($sformatf("vec%0d_rs", i), data_rs, vecs[i].exp_rs);
            check($sformatf("vec%0d_rt", i), data_rt, vecs[i].exp_rt);
            check($sformatf("vec%0d_dbg", i), dbg_data, vecs[i].exp_dbg);
            check($sformatf("vec%0d_cnt", i), 32'(wr_count), vecs[i].exp_cnt);
            check($sformatf("vec%0d_last", i), 32'(last_wr_addr), vecs[i].exp_last);
        end

        // Same-cycle read of the address being written.
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'hA5A5A5A5;
`else
        exp_same = 32'd12;
`endif
        drive(1'b1, 1'b1, 5'd12, 32'hA5A5A5A5, 5'd12, 5'd12, 5'd12);
        #1;
        check("same_cycle_rs", data_rs, exp_same);
        check("same_cycle_rt", data_rt, exp_same);
        check("same_cycle_dbg", dbg_data, exp_same);
        tick();
        check("next_cycle_rs", data_rs, 32'hA5A5A5A5);
        check("next_cycle_rt", data_rt, 32'hA5A5A5A5);
        check("next_cycle_cnt", 32'(wr_count), 32'd4);
        check("next_cycle_last", 32'(last_wr_addr), 32'd12);

        // A $0 write never bypasses, even in the same cycle.
        drive(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        #1;
        check("zero_bypass_rs", data_rs, 32'd0);
        check("zero_bypass_dbg", dbg_data, 32'd0);
        tick();
        check("zero_write_cnt", 32'(wr_count), 32'd4);

        // 12 more commits: 16 in total since reset, so the 4-bit counter wraps to 0.
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 1'b1, 5'd20, 32'(k + 100), 5'd20, 5'd0, 5'd0);
            tick();
            if (k == 10) check("cnt_before_wrap", 32'(wr_count), 32'd15);
        end
        check("cnt_wrapped", 32'(wr_count), 32'd0);
        check("wrap_last", 32'(last_wr_addr), 32'd20);
        check("wrap_data", data_rs, 32'd111);

        // Mid-stream reset alongside a commit to $3.
        reset = 1'b1;
        drive(1'b1, 1'b1, 5'd3, 32'h0000CAFE, 5'd3, 5'd5, 5'd20);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ctl_reg_write = 1'b0;
        #1;
        check("rst2_reg3", data_rs, 32'd3);
        check("rst2_reg5", data_rt, 32'd5);
        check("rst2_reg20", dbg_data, 32'd20);
        check("rst2_cnt", 32'(wr_count), 32'd0);
        check("rst2_last", 32'(last_wr_addr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
